// File: rtl/audio_pkg.sv
// Shared audio-path types and constants.
// Used by the capture front end and the echo buffer.
package audio_pkg;

  localparam int unsigned ECHO_DEPTH = 2048;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RECORDING,
    FULL
  } rec_state_t;

endpackage

// File: rtl/record_capture_front_if.sv
// Sample-stream bundle between the mic source
// and the capture front end.
interface record_capture_front_if;
  import audio_pkg::*;

  logic signed [15:0] mic_in;
  logic               mic_valid_in;
  logic signed [15:0] audio_out;
  logic               audio_valid_out;
  logic               record_out;
  logic               full_out;
  logic        [15:0] sample_count_out;

  modport master (
    output mic_in,
    output mic_valid_in,
    input  audio_out,
    input  audio_valid_out,
    input  record_out,
    input  full_out,
    input  sample_count_out
  );

  modport slave (
    input  mic_in,
    input  mic_valid_in,
    output audio_out,
    output audio_valid_out,
    output record_out,
    output full_out,
    output sample_count_out
  );

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a
// stable-level debouncer.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          flip_d;

  // Count consecutive cycles the synced level disagrees.
  always_comb begin
    cnt_d  = '0;
    flip_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        flip_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, counter and accepted level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      if (flip_d) begin
        level_q <= sync2_q;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/record_capture_front.sv
// Mic decimator, record-button debounce and
// take-length limiter ahead of the echo buffer.
module record_capture_front
  import audio_pkg::*;
#(
  parameter int unsigned AVG_LOG2        = 2,
  parameter int unsigned MAX_SAMPLES     = ECHO_DEPTH,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   record_btn_in,
  record_capture_front_if.slave  bus
);

  localparam int unsigned AW = 16 + AVG_LOG2;
  localparam int unsigned CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [15:0] CNT_MAX = 16'(MAX_SAMPLES);

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] sum_d;
  logic signed [15:0]   avg_d;
  logic        [CW-1:0] cnt_q;
  logic                 done_d;
  logic signed [15:0]   audio_q;
  logic                 valid_q;
  rec_state_t           state_q;
  logic                 rec_q;
  logic                 full_q;
  logic        [15:0]   count_q;
  logic                 db;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .btn_i   (record_btn_in),
    .level_o (db)
  );

  // Running sum including the current sample.
  always_comb begin
    sum_d  = acc_q + AW'(bus.mic_in);
    avg_d  = 16'(sum_d >>> AVG_LOG2);
    done_d = bus.mic_valid_in && (cnt_q == LAST);
  end

  // Block averager; the completing sample joins its own block.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      audio_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= done_d;
      if (bus.mic_valid_in) begin
        if (done_d) begin
          acc_q   <= '0;
          cnt_q   <= '0;
          audio_q <= avg_d;
        end else begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Take FSM; the sample that starts a take is itself recorded.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      rec_q   <= 1'b0;
      full_q  <= 1'b0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (db) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (!db) begin
            state_q <= IDLE;
          end else if (done_d) begin
            state_q <= RECORDING;
            rec_q   <= 1'b1;
            count_q <= 16'd1;
          end
        end
        RECORDING: begin
          if (done_d) begin
            if (!db) begin
              state_q <= IDLE;
              rec_q   <= 1'b0;
            end else if (count_q == CNT_MAX) begin
              state_q <= FULL;
              rec_q   <= 1'b0;
              full_q  <= 1'b1;
            end else begin
              count_q <= count_q + 16'd1;
            end
          end
        end
        FULL: begin
          if (!db) begin
            state_q <= IDLE;
            full_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rec_q   <= 1'b0;
          full_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.audio_out        = audio_q;
  assign bus.audio_valid_out  = valid_q;
  assign bus.record_out       = rec_q;
  assign bus.full_out         = full_q;
  assign bus.sample_count_out = count_q;

endmodule

// File: tb/tb_record_capture_front.sv
// Bench for record_capture_front: reference model
// plus directed take scenarios.
module tb_record_capture_front;
  import audio_pkg::*;

  localparam int A    = 2;
  localparam int MAXS = 8;
  localparam int DB   = 16;
  localparam int BLK  = 1 << A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  record_capture_front_if bus ();

  record_capture_front #(
    .AVG_LOG2        (A),
    .MAX_SAMPLES     (MAXS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .record_btn_in (btn),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  int m_audio = 0;
  int m_valid = 0;
  int m_rec   = 0;
  int m_full  = 0;
  int m_count = 0;
  int blk[$];
  int take[$];
  int mode = 0;   // 0 idle, 1 armed, 2 recording, 3 full
  int btn_hist[$];
  int mdb = 0;

  // Debounced level: flips once the button, seen two cycles late,
  // has disagreed with it for DB consecutive samples.
  function automatic void update_db();
    int n;
    int same;
    n = btn_hist.size();
    if (n < DB + 2) return;
    same = 1;
    for (int i = n - DB - 2; i < n - 2; i++) begin
      if (btn_hist[i] == mdb) same = 0;
    end
    if (same) begin
      mdb = 1 - mdb;
      btn_hist.delete();
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_audio = 0; m_valid = 0; m_rec = 0;
        m_full = 0; m_count = 0; mode = 0; mdb = 0;
        blk.delete(); take.delete(); btn_hist.delete();
      end else begin
        int done;
        int sum;
        int q;
        done = 0;
        if (bus.mic_valid_in) begin
          blk.push_back(int'(bus.mic_in));
          if (blk.size() == BLK) begin
            sum = 0;
            foreach (blk[i]) sum += blk[i];
            q = sum / BLK;
            if (sum < 0 && q * BLK != sum) q = q - 1;
            m_audio = q;
            done = 1;
            blk.delete();
          end
        end
        m_valid = done;
        case (mode)
          0: if (mdb == 1) mode = 1;
          1: begin
            if (mdb == 0) mode = 0;
            else if (done == 1) begin
              take.delete();
              take.push_back(m_audio);
              mode = 2;
            end
          end
          2: begin
            if (done == 1) begin
              if (mdb == 0) mode = 0;
              else if (take.size() >= MAXS) mode = 3;
              else take.push_back(m_audio);
            end
          end
          default: if (mdb == 0) mode = 0;
        endcase
        m_count = take.size();
        m_rec   = (mode == 2) ? 1 : 0;
        m_full  = (mode == 3) ? 1 : 0;
        btn_hist.push_back(int'(btn));
        update_db();
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("audio", int'(bus.audio_out), m_audio);
      chk("valid", int'(bus.audio_valid_out), m_valid);
      chk("record", int'(bus.record_out), m_rec);
      chk("full", int'(bus.full_out), m_full);
      chk("count", int'(bus.sample_count_out), m_count);
    end
  end

  task automatic send(input int x);
    bus.mic_valid_in = 1'b1;
    bus.mic_in = 16'(x);
    @(negedge clk);
    bus.mic_valid_in = 1'b0;
  endtask

  task automatic block(input int x);
    for (int i = 0; i < BLK; i++) send(x + i);
  endtask

  int nrec;

  initial begin
    bus.mic_valid_in = 1'b0;
    bus.mic_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_audio", int'(bus.audio_out), 0);
    chk("rst_valid", int'(bus.audio_valid_out), 0);
    chk("rst_count", int'(bus.sample_count_out), 0);
    rst = 1'b0;
    @(negedge clk);

    send(100); send(200); send(-300); send(-1);
    chk("avg_mixed_valid", int'(bus.audio_valid_out), 1);
    chk("avg_mixed", int'(bus.audio_out), -1);
    @(negedge clk);
    chk("avg_pulse_width", int'(bus.audio_valid_out), 0);

    for (int i = 0; i < 4; i++) send(32767);
    chk("avg_max", int'(bus.audio_out), 32767);
    for (int i = 0; i < 4; i++) send(-32768);
    chk("avg_min", int'(bus.audio_out), -32768);

    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_idle", int'(dut.state_q), int'(IDLE));

    btn = 1'b1;
    repeat (20) @(negedge clk);
    chk("armed", int'(dut.state_q), int'(ARMED));
    nrec = 0;
    for (int k = 0; k < 12; k++) begin
      block(10 * k);
      if (bus.audio_valid_out && bus.record_out) nrec++;
      if (k == 0) begin
        chk("first_rec", int'(bus.record_out), 1);
        chk("first_count", int'(bus.sample_count_out), 1);
      end
      @(negedge clk);
    end
    chk("full_pulses", nrec, 8);
    chk("full_flag", int'(bus.full_out), 1);
    chk("full_count", int'(bus.sample_count_out), 8);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("rel_full", int'(bus.full_out), 0);
    chk("rel_count", int'(bus.sample_count_out), 8);
    chk("rel_idle", int'(dut.state_q), int'(IDLE));

    btn = 1'b1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      block(-7 * k);
      @(negedge clk);
    end
    chk("five_count", int'(bus.sample_count_out), 5);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    block(3);
    chk("sixth_valid", int'(bus.audio_valid_out), 1);
    chk("sixth_rec", int'(bus.record_out), 0);
    chk("sixth_count", int'(bus.sample_count_out), 5);
    @(negedge clk);

    btn = 1'b1;
    repeat (20) @(negedge clk);
    block(50);
    block(60);
    chk("mid_rec", int'(bus.record_out), 1);
    send(1000); send(1000);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_audio", int'(bus.audio_out), 0);
    chk("mrst_rec", int'(bus.record_out), 0);
    chk("mrst_full", int'(bus.full_out), 0);
    chk("mrst_count", int'(bus.sample_count_out), 0);
    rst = 1'b0;
    send(8); send(8); send(8); send(12);
    chk("fresh_valid", int'(bus.audio_valid_out), 1);
    chk("fresh_avg", int'(bus.audio_out), 9);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
